serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
- Controller that runs one 1-bit full-subtractor cell (minuend, subtrahend, carry_in as borrow-in) over WIDTH clock cycles, LSB first, to form an N-bit difference.
- Handles operand capture, bit sequencing, the borrow chain between cycles, result assembly and a start/busy/done handshake.
- Sits between a requesting datapath and the shared 1-bit subtractor cell, so a wide subtraction costs one cell.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend operand; captured on an accepted start.
- b  input  WIDTH  subtrahend operand; captured on an accepted start.
- busy  output  1  high while the subtraction is being sequenced.
- done  output  1  one-cycle pulse when the result is valid.
- difference  output  WIDTH  a - b modulo 2^WIDTH; registered output.
- borrow_out  output  1  final borrow; 1 when a < b unsigned.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, difference=0, borrow_out=0; shift registers, bit counter and borrow flop cleared.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on a rising edge with start=1.
  - Load a and b into operand shift registers.
  - Clear the borrow flop to 0 and the bit counter to 0.
- RUN, every cycle:
  - Feed the cell: minuend=a_sr[0], subtrahend=b_sr[0], carry_in=borrow flop.
  - d = m ^ s ^ bin.
  - bout = (~m & s) | (~(m ^ s) & bin).
  - Shift d into the MSB of the result shift register; shift both operand registers right by 1.
  - Borrow flop <= bout; counter += 1.
- RUN -> DONE: on the edge that processes bit WIDTH-1.
  - difference is loaded from the completed result shift register and borrow_out from the final bout, on that same edge.
- DONE -> IDLE: unconditionally after one cycle. done=1 only while in DONE.
- busy=1 exactly while in RUN. Latency: start sampled at edge k; busy is high for WIDTH cycles; done is high in the cycle after edge k+WIDTH.
- difference and borrow_out hold their values until the next completion. They do not change during RUN.
- start while in RUN or DONE is ignored (no queueing). A start in the first IDLE cycle after DONE is accepted, so back-to-back throughput is one result per WIDTH+2 cycles.
- a and b may change freely after capture with no effect on the result.
- Reset during RUN aborts the operation: done is never asserted and outputs are cleared immediately.
- Arithmetic is unsigned modulo 2^WIDTH. borrow_out is the unsigned borrow.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0.
  - On the start capture, register a_msb and b_msb.
  - At completion, overflow <= (a_msb != b_msb) && (difference_msb != a_msb), i.e. two's-complement signed overflow.
  - Updated on the same edge as difference and held with it.
- Not defined: no overflow port and no extra flops; behaviour otherwise identical.

Test Plan:
- Reset: assert rst with no clock edge -> busy=0, done=0, difference=0x00, borrow_out=0 immediately.
- WIDTH=8, a=100, b=37, start for 1 cycle -> busy high for exactly 8 cycles, then done for 1 cycle; difference=0x3F, borrow_out=0.
- Borrow and wrap cases:
  - a=0x05, b=0x0A -> difference=0xFB, borrow_out=1.
  - a=0x00, b=0x01 -> difference=0xFF, borrow_out=1.
  - a=0xFF, b=0xFF -> difference=0x00, borrow_out=0.
- Handshake:
  - Hold start=1 with a=0x10, b=0x01 and change to a=0xAA, b=0x55 mid-RUN -> single result 0x0F; start high during DONE is ignored.
  - Next start in the following IDLE cycle is accepted and returns 0x55.
- Abort: a=0x80, b=0x01, assert rst in the 4th RUN cycle -> outputs clear at once and no done pulse; a following start a=0x09, b=0x03 -> difference=0x06.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=0x80, b=0x01 -> difference=0x7F, overflow=1, borrow_out=0.
  - a=0x10, b=0x01 -> overflow=0.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: sequences one 1-bit full subtractor over WIDTH cycles, LSB first.
// Optional: define SERIAL_SUB_OVERFLOW_EN to add a signed overflow output.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             m, s, cell_d, cell_b;
  logic [WIDTH-1:0] full;
  logic             last;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  assign last = (cnt_q == LAST);

  // The shared subtractor cell plus the result word with the new bit on top
  always_comb begin
    m      = a_sr_q[0];
    s      = b_sr_q[0];
    cell_d = m ^ s ^ bor_q;
    cell_b = (~m & s) | (~(m ^ s) & bor_q);
    full   = {cell_d, res_q};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state: capture, shift, borrow chain, completion load
  always_comb begin
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    bor_d  = bor_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    if (state_q == IDLE && start) begin
      a_sr_d = a;
      b_sr_d = b;
      res_d  = '0;
      cnt_d  = '0;
      bor_d  = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      a_sr_d = a_sr_q >> 1;
      b_sr_d = b_sr_q >> 1;
      res_d  = full[WIDTH-1:1];
      cnt_d  = cnt_q + CW'(1);
      bor_d  = cell_b;
      if (last) begin
        diff_d = full;
        bout_d = cell_b;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      bor_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      bor_q  <= bor_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign difference = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule
